dmem_port_router: RTL and testbench
===================================

# dmem_port_router

Routes the single shared data-memory port between the four cores according to the `memory_mode` code issued by the control unit.
- Load modes (1–4) fetch a word at core N's address register and return it to core N.
- Store modes (5–8) write core N's data word to core N's address.

The block sits directly downstream of the control unit, between the per-core AR/DR registers and the synchronous data RAM. Each operation is triggered once per mode entry.

## Interface
Parameters:
- `DATA_WIDTH`, 16, data word width
- `ADDR_WIDTH`, 16, data-memory address width
- `NUM_CORES`, 4, number of cores; fixed at 4 for the mode encoding

Ports:
- `clock`  in  1  single system clock, rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `memory_mode`  in  4  from control unit: 0 idle, 1–4 load core 1–4, 5–8 store core 1–4, 9–15 illegal
- `core_addr`  in  NUM_CORES*ADDR_WIDTH  AR of each core; core N is the slice [N*ADDR_WIDTH +: ADDR_WIDTH], with N starting at 0
- `core_wdata`  in  NUM_CORES*DATA_WIDTH  DR of each core, same packing as `core_addr`
- `mem_rdata`  in  DATA_WIDTH  RAM read data, valid one cycle after the address
- `mem_addr`  out  ADDR_WIDTH  registered RAM address
- `mem_wdata`  out  DATA_WIDTH  registered RAM write data
- `mem_we`  out  1  registered RAM write strobe
- `core_rdata`  out  NUM_CORES*DATA_WIDTH  per-core returned read word, held until the next load to that core
- `core_rdata_valid`  out  NUM_CORES  one-cycle pulse per core when its `core_rdata` updates
- `busy`  out  1  high while a load or store is in flight
- `mode_err`  out  1  sticky flag: an illegal mode was seen

## Operation
- **Mode-entry detection**
  - `mode_q` registers `memory_mode` every cycle.
  - A new operation starts only when `memory_mode != mode_q` and `memory_mode` is 1–8.
  - Holding the same mode for any number of cycles performs exactly one operation.
  - Going back to 0, or to a different mode, re-arms detection.
- **State machine**, states IDLE, RD_ADDR, RD_CAP, WR.
  - IDLE: on a load-entry for core N, load `mem_addr <= core_addr[N]`, force `mem_we <= 0`, latch `tgt <= N`, and go to RD_ADDR. On a store-entry for core N, load `mem_addr <= core_addr[N]` and `mem_wdata <= core_wdata[N]`, set `mem_we <= 1`, and go to WR.
  - RD_ADDR: wait for the RAM read latency (address presented to the RAM); go to RD_CAP.
  - RD_CAP: `core_rdata[tgt] <= mem_rdata`; pulse `core_rdata_valid[tgt]`; go to IDLE.
  - WR: `mem_we <= 0`; go to IDLE. The write strobe is exactly one cycle wide.
- **Entries arriving outside IDLE**
  - A mode entry that arrives while the FSM is not in IDLE is remembered in a one-deep pending slot (mode and core index).
  - The pending entry is started in the cycle the FSM returns to IDLE.
  - A second entry arriving while the slot is already full overwrites the slot, and `mode_err` is set.
- **Operand sampling**
  - An in-flight read always completes to the core latched in `tgt`, even if `memory_mode` changes meanwhile.
  - Address and data are sampled when the operation starts, not when the entry is detected. Because of this, the control unit must hold AR/DR stable for the duration of the mode.
- **Other rules**
  - Modes 9–15 are treated as idle and set `mode_err`. It stays set until reset.
  - `mem_addr` and `mem_wdata` hold their last value in IDLE.
  - `busy` = (state != IDLE) or pending slot full.
- **Reset** (asynchronous assert, mid-operation included): state IDLE, `mode_q` = 0, pending slot empty, and every output forced to 0, including `mem_we`, all `core_rdata`, valids, `busy` and `mode_err`. A read or write that was in flight is dropped.

## Timing
- Load: `memory_mode` = N appears in cycle t.
  - `mem_addr` is valid from t+1.
  - The RAM returns data in t+2.
  - `core_rdata[N-1]` updates and the valid pulses in t+3.
  - Load latency is 3 cycles.
- Store: mode appears in cycle t; `mem_we` = 1 with address and data valid during t+1 only. Store latency is 1 cycle.
- Back-to-back entries on consecutive cycles: the second entry is queued and starts the cycle after the FSM returns to IDLE.
- Reset deassertion must be released synchronously by the system reset network. The first active edge after release samples `memory_mode` into `mode_q`.

## Test plan
- **Load:** set `core_addr[1]` = 0x0040, preload RAM[0x40] = 0xBEEF, and drive mode 2 for 2 cycles → `mem_addr` = 0x0040 at t+1, `core_rdata[1]` = 0xBEEF and `core_rdata_valid` = 0010 at t+3, `mem_we` never asserted.
- **Store:** set `core_addr[3]` = 0x0007, `core_wdata[3]` = 0x1234, and drive mode 8 for 3 cycles → exactly one `mem_we` pulse at t+1 with addr 0x0007 / data 0x1234; RAM[7] reads back 0x1234.
- **Sequenced stores and held modes:** drive modes 5,5,5,6,6,6,7,7,7,8,8,8 → exactly 4 write pulses in core order 0..3, none repeated.
- **Queued load:** drive mode 1 then mode 3 on the next cycle → core 0's load completes at t+3, core 2's load starts at t+3, `busy` stays high throughout, `mode_err` stays 0.
- **Illegal mode:** drive mode 12 → no RAM access and `mode_err` = 1. A later legal load still completes, and `mode_err` stays set until reset.
- **Reset mid-load:** assert `reset_n` = 0 in cycle t+2 of a load → all outputs 0 immediately and no valid pulse; after release, mode 0 keeps the block idle.

Source files
------------

// File: rtl/dmem_port_router.sv
// Shares one synchronous data-RAM port among four cores: loads return in 3 cycles, stores strobe once after 1.
// No backpressure: an entry that arrives while busy waits in a one-deep slot; a second overwrites it and flags mode_err.
module dmem_port_router #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_CORES  = 4
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [3:0]                       memory_mode,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]  core_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  output logic                             mem_we,
  output logic [NUM_CORES*DATA_WIDTH-1:0]  core_rdata,
  output logic [NUM_CORES-1:0]             core_rdata_valid,
  output logic                             busy,
  output logic                             mode_err
);

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_CAP, WR} state_t;

  state_t     state, state_nxt;
  logic [3:0] mode_q;
  logic       entry, entry_st;
  logic [1:0] entry_core;
  logic       pend_vld, pend_st;
  logic [1:0] pend_core;
  logic [1:0] tgt;
  logic       go, go_st;
  logic [1:0] go_core;
  logic       pend_set, pend_clr, err_set;

  // Modes 1-4 and 5-8 both map to core (mode-1) mod 4.
  assign entry      = (memory_mode != mode_q) && (memory_mode >= 4'd1) && (memory_mode <= 4'd8);
  assign entry_st   = (memory_mode >= 4'd5);
  assign entry_core = memory_mode[1:0] - 2'd1;

  assign busy = (state != IDLE) || pend_vld;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    go_st     = 1'b0;
    go_core   = 2'd0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    err_set   = (memory_mode >= 4'd9);
    case (state)
      IDLE: begin
        if (pend_vld) begin
          // The queued entry has priority; a simultaneous new entry refills the slot being drained.
          go       = 1'b1;
          go_st    = pend_st;
          go_core  = pend_core;
          pend_clr = 1'b1;
          pend_set = entry;
        end else if (entry) begin
          go      = 1'b1;
          go_st   = entry_st;
          go_core = entry_core;
        end
        if (go) state_nxt = go_st ? WR : RD_ADDR;
      end
      RD_ADDR: state_nxt = RD_CAP;
      RD_CAP:  state_nxt = IDLE;
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && entry) begin
      pend_set = 1'b1;
      if (pend_vld) err_set = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q           <= 4'd0;
      pend_vld         <= 1'b0;
      pend_st          <= 1'b0;
      pend_core        <= 2'd0;
      tgt              <= 2'd0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      mem_we           <= 1'b0;
      core_rdata       <= '0;
      core_rdata_valid <= '0;
      mode_err         <= 1'b0;
    end else begin
      mode_q           <= memory_mode;
      core_rdata_valid <= '0;
      if (err_set) mode_err <= 1'b1;

      if (pend_set) begin
        pend_vld  <= 1'b1;
        pend_st   <= entry_st;
        pend_core <= entry_core;
      end else if (pend_clr) begin
        pend_vld <= 1'b0;
      end

      if (go) begin
        mem_addr <= core_addr[go_core*ADDR_WIDTH +: ADDR_WIDTH];
        if (go_st) begin
          mem_wdata <= core_wdata[go_core*DATA_WIDTH +: DATA_WIDTH];
          mem_we    <= 1'b1;
        end else begin
          mem_we <= 1'b0;
          tgt    <= go_core;
        end
      end else if (state == WR) begin
        mem_we <= 1'b0;
      end

      if (state == RD_CAP) begin
        core_rdata[tgt*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
        core_rdata_valid[tgt]                    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_router.sv
// Directed bench for dmem_port_router with a 1-cycle synchronous RAM model.
module tb_dmem_port_router;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  memory_mode;
  logic [63:0] core_addr;
  logic [63:0] core_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [63:0] core_rdata;
  logic [3:0]  core_rdata_valid;
  logic        busy;
  logic        mode_err;

  logic [15:0] ram [0:255];
  logic        pl_we;
  logic [7:0]  pl_addr;
  logic [15:0] pl_dat;

  int checks = 0;
  int errors = 0;

  dmem_port_router #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_CORES(4)) dut (
    .clock(clock), .reset_n(reset_n), .memory_mode(memory_mode),
    .core_addr(core_addr), .core_wdata(core_wdata), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .core_rdata(core_rdata), .core_rdata_valid(core_rdata_valid),
    .busy(busy), .mode_err(mode_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pl_we)       ram[pl_addr] <= pl_dat;
    else if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_we = 1'b1; pl_addr = a; pl_dat = d;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; memory_mode = 4'd0; core_addr = '0; core_wdata = '0;
    pl_we = 1'b0; pl_addr = '0; pl_dat = '0;
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    tick(); tick();
    checks++;
    if ({mem_addr, mem_wdata, mem_we, core_rdata, core_rdata_valid, busy, mode_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h wdata=%h we=%b rdata=%h vld=%b busy=%b err=%b, need all 0",
               mem_addr, mem_wdata, mem_we, core_rdata, core_rdata_valid, busy, mode_err);
    end
    reset_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_load();
    int we_seen = 0;
    core_addr[16 +: 16] = 16'h0040;
    preload(8'h40, 16'hBEEF);
    memory_mode = 4'd2;
    tick(); // t+1
    if (mem_we) we_seen++;
    checks++;
    if (mem_addr !== 16'h0040) begin errors++; $display("FAIL load_addr: got %h need 0040", mem_addr); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %b need 1", busy); end
    tick(); // t+2
    memory_mode = 4'd0;
    if (mem_we) we_seen++;
    checks++;
    if (core_rdata_valid !== 4'b0000) begin errors++; $display("FAIL load_early_vld: got %b need 0000", core_rdata_valid); end
    tick(); // t+3
    if (mem_we) we_seen++;
    checks++;
    if (core_rdata[16 +: 16] !== 16'hBEEF) begin errors++; $display("FAIL load_data: got %h need beef", core_rdata[16 +: 16]); end
    checks++;
    if (core_rdata_valid !== 4'b0010) begin errors++; $display("FAIL load_vld: got %b need 0010", core_rdata_valid); end
    tick();
    if (mem_we) we_seen++;
    checks++;
    if (core_rdata_valid !== 4'b0000) begin errors++; $display("FAIL load_vld_pulse: got %b need 0000", core_rdata_valid); end
    checks++;
    if (we_seen != 0) begin errors++; $display("FAIL load_no_we: got %0d strobes need 0", we_seen); end
  endtask

  task automatic test_store();
    int cnt = 0;
    core_addr[48 +: 16] = 16'h0007;
    core_wdata[48 +: 16] = 16'h1234;
    memory_mode = 4'd8;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 3) memory_mode = 4'd0;
      if (mem_we) cnt++;
      if (i == 1) begin
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0007, 16'h1234}) begin
          errors++;
          $display("FAIL store_t1: got we=%b addr=%h data=%h need 1/0007/1234", mem_we, mem_addr, mem_wdata);
        end
      end
    end
    checks++;
    if (cnt != 1) begin errors++; $display("FAIL store_count: got %0d need 1", cnt); end
    checks++;
    if (ram[7] !== 16'h1234) begin errors++; $display("FAIL store_ram: got %h need 1234", ram[7]); end
  endtask

  task automatic test_seq_stores();
    int seq [12] = '{5, 5, 5, 6, 6, 6, 7, 7, 7, 8, 8, 8};
    logic [15:0] wa [8];
    logic [15:0] wd [8];
    int nw = 0;
    for (int i = 0; i < 4; i++) begin
      core_addr[16*i +: 16]  = 16'h0010 + 16'(i);
      core_wdata[16*i +: 16] = 16'hA000 + 16'(i);
    end
    for (int k = 0; k < 16; k++) begin
      memory_mode = (k < 12) ? 4'(seq[k]) : 4'd0;
      tick();
      if (mem_we) begin
        if (nw < 8) begin wa[nw] = mem_addr; wd[nw] = mem_wdata; end
        nw++;
      end
    end
    checks++;
    if (nw != 4) begin errors++; $display("FAIL seq_count: got %0d need 4", nw); end
    for (int i = 0; i < 4; i++) begin
      if (i < nw) begin
        checks++;
        if (wa[i] !== 16'h0010 + 16'(i) || wd[i] !== 16'hA000 + 16'(i)) begin
          errors++;
          $display("FAIL seq_order[%0d]: got %h/%h need %h/%h", i, wa[i], wd[i],
                   16'h0010 + 16'(i), 16'hA000 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_queued_load();
    core_addr[0 +: 16]  = 16'h0020;
    core_addr[32 +: 16] = 16'h0022;
    preload(8'h20, 16'h1111);
    preload(8'h22, 16'h3333);
    memory_mode = 4'd1;
    tick(); // t+1
    memory_mode = 4'd3;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL queue_busy[1]: got %b need 1", busy); end
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (c == 4) memory_mode = 4'd0;
      if (c <= 5) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL queue_busy[%0d]: got %b need 1", c, busy); end
      end
      if (c == 3) begin
        checks++;
        if (core_rdata_valid !== 4'b0001 || core_rdata[0 +: 16] !== 16'h1111) begin
          errors++; $display("FAIL queue_first: got vld=%b data=%h need 0001/1111", core_rdata_valid, core_rdata[0 +: 16]);
        end
      end
      if (c == 4) begin
        checks++;
        if (mem_addr !== 16'h0022) begin errors++; $display("FAIL queue_second_addr: got %h need 0022", mem_addr); end
      end
      if (c == 6) begin
        checks++;
        if (core_rdata_valid !== 4'b0100 || core_rdata[32 +: 16] !== 16'h3333) begin
          errors++; $display("FAIL queue_second: got vld=%b data=%h need 0100/3333", core_rdata_valid, core_rdata[32 +: 16]);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL queue_idle: got busy=%b need 0", busy); end
      end
    end
    checks++;
    if (mode_err !== 1'b0) begin errors++; $display("FAIL queue_err: got %b need 0", mode_err); end
  endtask

  task automatic test_illegal();
    memory_mode = 4'd12;
    tick();
    checks++;
    if (mode_err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b need 1", mode_err); end
    tick();
    checks++;
    if ({mem_we, busy, core_rdata_valid} !== 6'b0 || mem_addr !== 16'h0022) begin
      errors++; $display("FAIL illegal_noaccess: got we=%b busy=%b vld=%b addr=%h need 0/0/0000/0022",
                         mem_we, busy, core_rdata_valid, mem_addr);
    end
    memory_mode = 4'd0;
    core_addr[48 +: 16] = 16'h0030;
    preload(8'h30, 16'h4444);
    memory_mode = 4'd4;
    tick();
    memory_mode = 4'd0;
    tick();
    tick();
    checks++;
    if (core_rdata_valid !== 4'b1000 || core_rdata[48 +: 16] !== 16'h4444) begin
      errors++; $display("FAIL illegal_then_load: got vld=%b data=%h need 1000/4444", core_rdata_valid, core_rdata[48 +: 16]);
    end
    checks++;
    if (mode_err !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b need 1", mode_err); end
  endtask

  task automatic test_reset_mid_load();
    int vld_seen = 0;
    memory_mode = 4'd2;
    tick(); // t+1
    tick(); // t+2
    reset_n = 1'b0;
    memory_mode = 4'd0;
    #1;
    checks++;
    if ({mem_addr, mem_wdata, mem_we, core_rdata, core_rdata_valid, busy, mode_err} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got addr=%h wdata=%h we=%b rdata=%h vld=%b busy=%b err=%b, need all 0",
               mem_addr, mem_wdata, mem_we, core_rdata, core_rdata_valid, busy, mode_err);
    end
    tick();
    if (core_rdata_valid !== 4'b0000) vld_seen++;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (core_rdata_valid !== 4'b0000) vld_seen++;
      checks++;
      if ({busy, mem_we} !== 2'b00 || mem_addr !== 16'h0000) begin
        errors++; $display("FAIL midreset_idle[%0d]: got busy=%b we=%b addr=%h need 0/0/0000", i, busy, mem_we, mem_addr);
      end
    end
    checks++;
    if (vld_seen != 0) begin errors++; $display("FAIL midreset_novld: got %0d pulses need 0", vld_seen); end
  endtask

  task automatic test_pend_overwrite();
    int bad_vld = 0;
    core_wdata[0 +: 16] = 16'h5555;
    memory_mode = 4'd1;
    tick(); // t+1
    memory_mode = 4'd3;
    tick(); // t+2
    memory_mode = 4'd5;
    tick(); // t+3
    memory_mode = 4'd0;
    checks++;
    if (mode_err !== 1'b1) begin errors++; $display("FAIL overwrite_err: got %b need 1", mode_err); end
    tick(); // t+4
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0020, 16'h5555}) begin
      errors++; $display("FAIL overwrite_store: got we=%b addr=%h data=%h need 1/0020/5555", mem_we, mem_addr, mem_wdata);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (core_rdata_valid[2]) bad_vld++;
    end
    checks++;
    if (bad_vld != 0) begin errors++; $display("FAIL overwrite_dropped: got %0d core2 pulses need 0", bad_vld); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_seq_stores();
    test_queued_load();
    test_illegal();
    test_reset_mid_load();
    test_pend_overwrite();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
